ddr_rx_word_assembler: RTL and testbench

//  Consumes the byte, parity and CRC fields produced by the HDR-DDR RX deserializer during a read data frame.

---
 rtl/ddr_rx_word_assembler.sv | 189 ++++++++++++++++++
 tb/tb_ddr_rx_word_assembler.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ddr_rx_word_assembler.sv
// HDR-DDR RX word assembler: packs byte pairs into parity-checked 16-bit words for the register file.
// Optional CRC5 engine built when DDR_RX_ASM_CRC_EN is defined; otherwise o_crc_err is tied 0.
module ddr_rx_word_assembler #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 32
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_frame_start,
  input  logic              i_rx_byte_valid,
  input  logic [7:0]        i_rx_byte,
  input  logic              i_rx_par_valid,
  input  logic [1:0]        i_rx_par,
  input  logic              i_rx_crc_valid,
  input  logic [4:0]        i_rx_crc,
  output logic              o_regf_wr_en,
  output logic [ADDR_W-1:0] o_regf_addr,
  output logic [15:0]       o_regf_wr_data,
  output logic [ADDR_W:0]   o_word_count,
  output logic              o_frame_done,
  output logic              o_par_err,
  output logic              o_crc_err,
  output logic              o_seq_err,
  output logic              o_ovf
);

  localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LP_MAX  = (ADDR_W + 1)'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] LP_ADDR_ONE = {{(ADDR_W - 1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LP_CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {StIdle, StHi, StLo, StPar, StDone} state_t;

  state_t              r_state;
  logic [7:0]          r_hi;
  logic [7:0]          r_lo;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_wr_data;
  logic [ADDR_W:0]     r_count;
  logic                r_frame_done;
  logic                r_par_err;
  logic                r_seq_err;
  logic                r_ovf;

  logic                w_multi;
  logic                w_any;
  logic [15:0]         w_word;
  logic [1:0]          w_calc_par;

  assign w_any   = i_rx_byte_valid | i_rx_par_valid | i_rx_crc_valid;
  assign w_multi = (i_rx_byte_valid & i_rx_par_valid) | (i_rx_byte_valid & i_rx_crc_valid) |
                   (i_rx_par_valid & i_rx_crc_valid);

  assign w_word     = {r_hi, r_lo};
  assign w_calc_par = {^(w_word & 16'hAAAA), ~^(w_word & 16'h5555)};

`ifdef DDR_RX_ASM_CRC_EN
  logic [4:0] r_crc;
  logic [7:0] r_fold_byte;
  logic       r_fold_pend;
  logic       r_crc_err;
  logic [4:0] w_crc_next;

  // x^5+x^2+1, byte fed MSB first, all 8 steps in one cycle
  always_comb begin
    w_crc_next = r_crc;
    for (int i = 7; i >= 0; i--) begin
      w_crc_next = {w_crc_next[3:0], 1'b0} ^ ({5{w_crc_next[4] ^ r_fold_byte[i]}} & 5'h05);
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_crc       <= 5'h1F;
      r_fold_byte <= 8'h00;
      r_fold_pend <= 1'b0;
      r_crc_err   <= 1'b0;
    end else if (i_frame_start) begin
      r_crc       <= 5'h1F;
      r_fold_pend <= 1'b0;
      r_crc_err   <= 1'b0;
    end else begin
      r_fold_pend <= 1'b0;
      if (r_fold_pend) r_crc <= w_crc_next;
      if (!w_multi && i_rx_byte_valid && (r_state == StHi || r_state == StLo)) begin
        r_fold_byte <= i_rx_byte;
        r_fold_pend <= 1'b1;
      end
      if (!w_multi && i_rx_crc_valid && r_state == StHi && i_rx_crc != r_crc) begin
        r_crc_err <= 1'b1;
      end
    end
  end

  assign o_crc_err = r_crc_err;
`else
  logic w_unused_crc;
  assign w_unused_crc = ^i_rx_crc;
  assign o_crc_err    = 1'b0;
`endif

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_state      <= StIdle;
      r_hi         <= 8'h00;
      r_lo         <= 8'h00;
      r_wr_en      <= 1'b0;
      r_addr       <= LP_BASE;
      r_wr_data    <= 16'h0000;
      r_count      <= '0;
      r_frame_done <= 1'b0;
      r_par_err    <= 1'b0;
      r_seq_err    <= 1'b0;
      r_ovf        <= 1'b0;
    end else if (i_frame_start) begin
      // Aborts any partial word; nothing is written for it
      r_state      <= StHi;
      r_wr_en      <= 1'b0;
      r_addr       <= LP_BASE;
      r_count      <= '0;
      r_frame_done <= 1'b0;
      r_par_err    <= 1'b0;
      r_seq_err    <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      if (r_wr_en) r_addr <= r_addr + LP_ADDR_ONE;
      if (w_multi) begin
        r_seq_err <= 1'b1;
      end else begin
        unique case (r_state)
          StIdle: if (w_any) r_seq_err <= 1'b1;
          StHi: begin
            if (i_rx_byte_valid) begin
              r_hi    <= i_rx_byte;
              r_state <= StLo;
            end else if (i_rx_crc_valid) begin
              r_frame_done <= 1'b1;
              r_state      <= StDone;
            end else if (i_rx_par_valid) begin
              r_seq_err <= 1'b1;
            end
          end
          StLo: begin
            if (i_rx_byte_valid) begin
              r_lo    <= i_rx_byte;
              r_state <= StPar;
            end else if (w_any) begin
              r_seq_err <= 1'b1;
            end
          end
          StPar: begin
            if (i_rx_par_valid) begin
              if (r_count == LP_MAX) begin
                r_ovf <= 1'b1;
              end else begin
                if (w_calc_par != i_rx_par) r_par_err <= 1'b1;
                r_wr_en   <= 1'b1;
                r_wr_data <= w_word;
                r_count   <= r_count + LP_CNT_ONE;
              end
              r_state <= StHi;
            end else if (w_any) begin
              r_seq_err <= 1'b1;
            end
          end
          StDone: begin
            if (w_any) r_seq_err <= 1'b1;
            r_state <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_regf_wr_en   = r_wr_en;
  assign o_regf_addr    = r_addr;
  assign o_regf_wr_data = r_wr_data;
  assign o_word_count   = r_count;
  assign o_frame_done   = r_frame_done;
  assign o_par_err      = r_par_err;
  assign o_seq_err      = r_seq_err;
  assign o_ovf          = r_ovf;

endmodule

// File: tb/tb_ddr_rx_word_assembler.sv
// Directed bench for ddr_rx_word_assembler; register-file writes are checked against a scoreboard queue.
module tb_ddr_rx_word_assembler;
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned MAX_WORDS = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fs = 1'b0;
  logic              bv = 1'b0;
  logic [7:0]        b = 8'h00;
  logic              pv = 1'b0;
  logic [1:0]        p = 2'b00;
  logic              cv = 1'b0;
  logic [4:0]        c = 5'h00;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;
  logic [ADDR_W:0]   wcount;
  logic              done, par_err, crc_err, seq_err, ovf;

  int n_tests = 0;
  int n_fail  = 0;
  logic [21:0] sb_q[$];

  ddr_rx_word_assembler #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .MAX_WORDS(MAX_WORDS)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_frame_start(fs),
    .i_rx_byte_valid(bv), .i_rx_byte(b), .i_rx_par_valid(pv), .i_rx_par(p),
    .i_rx_crc_valid(cv), .i_rx_crc(c),
    .o_regf_wr_en(wr_en), .o_regf_addr(addr), .o_regf_wr_data(wdata), .o_word_count(wcount),
    .o_frame_done(done), .o_par_err(par_err), .o_crc_err(crc_err), .o_seq_err(seq_err),
    .o_ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference parity: {xor of odd bits, xor of even bits inverted}
  function automatic logic [1:0] ref_par(input logic [15:0] w);
    logic p1 = 1'b0;
    logic p0 = 1'b1;
    for (int k = 0; k < 16; k += 2) begin
      p0 ^= w[k];
      p1 ^= w[k + 1];
    end
    return {p1, p0};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    fs = 1'b1; cyc(); fs = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    bv = 1'b1; b = v; cyc(); bv = 1'b0;
  endtask

  task automatic send_par(input logic [1:0] v);
    pv = 1'b1; p = v; cyc(); pv = 1'b0;
  endtask

  task automatic send_crc(input logic [4:0] v);
    cv = 1'b1; c = v; cyc(); cv = 1'b0;
  endtask

  // Monitor: every write must match the oldest expected {addr, data}
  always @(posedge clk) begin
    #1;
    if (wr_en === 1'b1) begin
      if (sb_q.size() == 0) chk("unexpected_write", {10'h0, addr, wdata}, 32'hFFFF_FFFF);
      else chk("write", {10'h0, addr, wdata}, {10'h0, sb_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(); cyc();
    chk("rst_outputs", {wr_en, done, par_err, crc_err, seq_err, ovf}, 6'b0);
    chk("rst_addr_count", {addr, wcount}, '0);
    rst = 1'b0;

    // Good frame
    start();
    sb_q.push_back({6'd0, 16'hA55A});
    send_byte(8'hA5); send_byte(8'h5A); send_par(2'b01);
    chk("t1_count", wcount, 1);
    cyc();
    send_crc(5'h17);
    chk("t1_done", done, 1);
    chk("t1_errs", {par_err, crc_err, seq_err, ovf}, 4'b0);
    cyc();
    chk("t1_done_pulse", done, 0);

    // Parity error, word still written
    start();
    sb_q.push_back({6'd0, 16'hA55A});
    send_byte(8'hA5); send_byte(8'h5A); send_par(2'b10);
    cyc();
    send_crc(5'h17);
    chk("t2_par_err", par_err, 1);
    chk("t2_crc_err", crc_err, 0);

    // Bad CRC
    start();
    sb_q.push_back({6'd0, 16'hA55A});
    send_byte(8'hA5); send_byte(8'h5A); send_par(2'b01);
    cyc();
    send_crc(5'h16);
    chk("t3_done", done, 1);
`ifdef DDR_RX_ASM_CRC_EN
    chk("t3_crc_err", crc_err, 1);
`else
    chk("t3_crc_err", crc_err, 0);
`endif
    chk("t3_par_err", par_err, 0);

    // Overflow
    start();
    for (int i = 0; i <= MAX_WORDS; i++) begin
      if (i < MAX_WORDS) sb_q.push_back({6'(i), 16'h0000});
      if (i == MAX_WORDS) chk("t4_no_ovf_yet", {ovf, wcount}, {1'b0, 7'(MAX_WORDS)});
      send_byte(8'h00); send_byte(8'h00); send_par(ref_par(16'h0000));
    end
    cyc();
    chk("t4_ovf", ovf, 1);
    chk("t4_count", wcount, MAX_WORDS);
    chk("t4_seq", seq_err, 0);
    send_crc(5'h00);
    chk("t4_done", done, 1);

    // Sequence error: parity in LO
    start();
    send_byte(8'h12); send_par(2'b01);
    cyc();
    chk("t5_seq", seq_err, 1);
    chk("t5_count", wcount, 0);
    start();
    chk("t5_clear", {seq_err, par_err, ovf}, 3'b0);
    // Simultaneous strobes are ignored, state stays HI
    bv = 1'b1; b = 8'hFF; pv = 1'b1; p = 2'b00; cyc(); bv = 1'b0; pv = 1'b0;
    chk("t5_multi", seq_err, 1);
    sb_q.push_back({6'd0, 16'h1234});
    send_byte(8'h12); send_byte(8'h34); send_par(ref_par(16'h1234));
    cyc();
    chk("t5_par_ok", par_err, 0);
    chk("t5_count2", wcount, 1);

    // Reset mid-word
    start();
    sb_q.push_back({6'd0, 16'hC3E1});
    send_byte(8'hC3); send_byte(8'hE1); send_par(ref_par(16'hC3E1));
    send_byte(8'h77);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("t6_rst_flags", {wr_en, done, par_err, crc_err, seq_err, ovf}, 6'b0);
    chk("t6_rst_addr_count", {addr, wcount}, '0);
    send_byte(8'h01);
    chk("t6_idle_seq", seq_err, 1);
    cyc(); cyc();
    chk("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
